// File: rtl/branch_predictor_pkg.sv
// Shared types, field layout and helpers for the tagged BTB with 2-bit direction counters.
package branch_predictor_pkg;

  localparam int unsigned IDX_W   = 10;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CTR_W   = 2;
  localparam int unsigned DEPTH   = 2 ** IDX_W;
  localparam int unsigned ENTRY_W = 1 + TAG_W + PC_W + CTR_W;

  // Bit offsets of each field inside a packed entry word
  localparam int unsigned CTR_LSB = 0;
  localparam int unsigned TGT_LSB = CTR_LSB + CTR_W;
  localparam int unsigned TAG_LSB = TGT_LSB + PC_W;
  localparam int unsigned VLD_BIT = TAG_LSB + TAG_W;

  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t CTR_SN = 2'b00;
  localparam ctr_t CTR_WN = 2'b01;
  localparam ctr_t CTR_WT = 2'b10;
  localparam ctr_t CTR_ST = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Field order matches the entry word {valid, tag, target, ctr}
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    ctr_t             ctr;
  } entry_t;

  function automatic logic [IDX_W-1:0] pc_idx(input logic [PC_W-1:0] pc);
    return pc[2 +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [PC_W-1:0] pc);
    return pc[2+IDX_W +: TAG_W];
  endfunction

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == CTR_ST) ? c : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == CTR_SN) ? c : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bp_entry_ram.sv
// 2-read/1-write synchronous RAM; read port 0 returns same-cycle write data on an address match.
module bp_entry_ram #(
  parameter int unsigned WIDTH = 43,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr0_i,
  output logic [WIDTH-1:0] rdata0_o,
  input  logic [AW-1:0]    raddr1_i,
  output logic [WIDTH-1:0] rdata1_o
);

  localparam int unsigned WORDS = 2 ** AW;

  logic [WIDTH-1:0] mem [WORDS];

  // Write port, write-first read port 0, read-old-data port 1
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata0_o <= (we_i && (waddr_i == raddr0_i)) ? wdata_i : mem[raddr0_i];
    rdata1_o <= mem[raddr1_i];
  end

endmodule

// File: rtl/branch_predictor.sv
// Tagged BTB with 2-bit saturating direction counters, 2-stage update RMW and a power-up flush.
module branch_predictor
  import branch_predictor_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  output logic            busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] fptr_q, fptr_d;

  logic             u1_vld_q;
  logic [IDX_W-1:0] u1_idx_q;
  logic [TAG_W-1:0] u1_tag_q;
  logic             u1_taken_q;
  logic [PC_W-1:0]  u1_target_q;
  logic             byp_q;
  entry_t           byp_entry_q;

  logic [TAG_W-1:0] lk_tag_q;
  entry_t           lk_entry;
  entry_t           upd_entry;

  logic             u0_acc_c;
  entry_t           u1_old_c;
  logic             u1_hit_c;
  logic             u1_we_c;
  entry_t           u1_wdata_c;

  logic             ram_we_c;
  logic [IDX_W-1:0] ram_waddr_c;
  entry_t           ram_wdata_c;
  logic             lk_hit_c;

  logic             unused_bits;

  assign unused_bits = ^{lookup_pc[PC_W-1:2+IDX_W+TAG_W], lookup_pc[1:0],
                         upd_pc[PC_W-1:2+IDX_W+TAG_W], upd_pc[1:0], lk_entry.ctr[0]};

  bp_entry_ram #(
    .WIDTH (ENTRY_W),
    .AW    (IDX_W)
  ) u_ram (
    .clk      (clk),
    .we_i     (ram_we_c),
    .waddr_i  (ram_waddr_c),
    .wdata_i  (ram_wdata_c),
    .raddr0_i (pc_idx(lookup_pc)),
    .rdata0_o (lk_entry),
    .raddr1_i (pc_idx(upd_pc)),
    .rdata1_o (upd_entry)
  );

  // Flush FSM state and pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FLUSH;
      fptr_q  <= '0;
    end else begin
      state_q <= state_d;
      fptr_q  <= fptr_d;
    end
  end

  // Flush walks every index once, then hands the table to normal operation
  always_comb begin
    state_d = state_q;
    fptr_d  = fptr_q;
    if (state_q == ST_FLUSH) begin
      fptr_d = fptr_q + IDX_W'(1);
      if (fptr_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  assign busy     = (state_q == ST_FLUSH);
  assign u0_acc_c = upd_en && (state_q == ST_RUN);

  // U1: merge bypassed/RAM entry with the resolved outcome
  always_comb begin
    u1_old_c   = byp_q ? byp_entry_q : upd_entry;
    u1_hit_c   = u1_old_c.valid && (u1_old_c.tag == u1_tag_q);
    u1_we_c    = 1'b0;
    u1_wdata_c = u1_old_c;
    if (u1_vld_q) begin
      if (u1_hit_c) begin
        u1_we_c = 1'b1;
        if (u1_taken_q) begin
          u1_wdata_c.ctr    = sat_inc(u1_old_c.ctr);
          u1_wdata_c.target = u1_target_q;
        end else begin
          u1_wdata_c.ctr    = sat_dec(u1_old_c.ctr);
        end
      end else if (u1_taken_q) begin
        u1_we_c    = 1'b1;
        u1_wdata_c = '{valid: 1'b1, tag: u1_tag_q, target: u1_target_q, ctr: CTR_WT};
      end
    end
  end

  // Single write port: flush clears, otherwise the U1 result
  always_comb begin
    ram_we_c    = u1_we_c;
    ram_waddr_c = u1_idx_q;
    ram_wdata_c = u1_wdata_c;
    if (state_q == ST_FLUSH) begin
      ram_we_c    = 1'b1;
      ram_waddr_c = fptr_q;
      ram_wdata_c = '0;
    end
  end

  // U0: latch the update and note whether this cycle's write must bypass the RAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      u1_vld_q <= 1'b0;
      byp_q    <= 1'b0;
    end else begin
      u1_vld_q <= u0_acc_c;
      byp_q    <= u0_acc_c && ram_we_c && (ram_waddr_c == pc_idx(upd_pc));
    end
    u1_idx_q    <= pc_idx(upd_pc);
    u1_tag_q    <= pc_tag(upd_pc);
    u1_taken_q  <= upd_taken;
    u1_target_q <= upd_target;
    byp_entry_q <= ram_wdata_c;
  end

  // Lookup tag travels alongside the RAM read
  always_ff @(posedge clk) begin
    lk_tag_q <= pc_tag(lookup_pc);
  end

  assign lk_hit_c    = !busy && lk_entry.valid && (lk_entry.tag == lk_tag_q);
  assign pred_taken  = lk_hit_c && lk_entry.ctr[1];
  assign pred_target = lk_hit_c ? lk_entry.target : '0;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic        ue;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] lpc;
    logic        etaken;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[$];

  branch_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (lookup_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_en      (upd_en),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic ue, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic [31:0] lpc,
                         input logic etaken, input logic [31:0] etgt);
    vec_t v;
    v.ue = ue; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.lpc = lpc; v.etaken = etaken; v.etgt = etgt;
    vecs.push_back(v);
  endtask

  // Count flush cycles (bounded) while checking that predictions stay gated
  task automatic run_flush(input string name, input int drop_upd_at);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    while (busy === 1'b1 && n < 2000) begin
      if (pred_taken !== 1'b0 || pred_target !== 32'h0) bad++;
      if (n == drop_upd_at) begin
        upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h300;
      end else begin
        upd_en = 1'b0;
      end
      step();
      n++;
    end
    upd_en = 1'b0;
    chk({name, "_len"}, 32'(n), 32'd1024);
    chk({name, "_pred_gated"}, 32'(bad), 32'd0);
    chk({name, "_busy_clear"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; lookup_pc = 32'h40;
    upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;

    // Each row: inputs for one cycle, expected prediction for that row's lookup.
    // An update in row k is written at the edge of row k+1 and seen write-first there.
    //       ue    upd_pc    t     upd_tgt     lookup     taken target
    add_vec(1'b0, 32'h0,    1'b0, 32'h0,     32'h40,   1'b0, 32'h0);    // 0 flush dropped update
    add_vec(1'b1, 32'h40,   1'b1, 32'h100,   32'h40,   1'b0, 32'h0);    // 1 U0 lookup sees old
    add_vec(1'b0, 32'h0,    1'b0, 32'h0,     32'h40,   1'b1, 32'h100);  // 2 alloc WT, write-first
    add_vec(1'b0, 32'h0,    1'b0, 32'h0,     32'h1040, 1'b0, 32'h0);    // 3 alias tag miss
    add_vec(1'b1, 32'h80,   1'b0, 32'hDEAD0, 32'h80,   1'b0, 32'h0);    // 4 miss not-taken
    add_vec(1'b0, 32'h0,    1'b0, 32'h0,     32'h80,   1'b0, 32'h0);    // 5 no allocation
    add_vec(1'b0, 32'h0,    1'b0, 32'h0,     32'h80,   1'b0, 32'h0);    // 6
    add_vec(1'b1, 32'h80,   1'b1, 32'h180,   32'h40,   1'b1, 32'h100);  // 7 miss taken
    add_vec(1'b0, 32'h0,    1'b0, 32'h0,     32'h80,   1'b1, 32'h180);  // 8 allocated at WT
    add_vec(1'b1, 32'h40,   1'b0, 32'hDEAD0, 32'h40,   1'b1, 32'h100);  // 9 WT -> WN
    add_vec(1'b0, 32'h0,    1'b0, 32'h0,     32'h40,   1'b0, 32'h100);  // 10 WN hit, target kept
    add_vec(1'b1, 32'h40,   1'b1, 32'h100,   32'h40,   1'b0, 32'h100);  // 11 WN -> WT
    add_vec(1'b1, 32'h40,   1'b1, 32'h100,   32'h40,   1'b1, 32'h100);  // 12 WT -> ST (bypass)
    add_vec(1'b1, 32'h40,   1'b1, 32'h100,   32'h40,   1'b1, 32'h100);  // 13 ST saturates
    add_vec(1'b1, 32'h40,   1'b0, 32'hDEAD0, 32'h40,   1'b1, 32'h100);  // 14 ST -> WT
    add_vec(1'b1, 32'h40,   1'b0, 32'hDEAD0, 32'h40,   1'b1, 32'h100);  // 15 WT -> WN
    add_vec(1'b0, 32'h0,    1'b0, 32'h0,     32'h40,   1'b0, 32'h100);  // 16 WN
    add_vec(1'b1, 32'h40,   1'b1, 32'h200,   32'h40,   1'b0, 32'h100);  // 17 WN -> WT, new target
    add_vec(1'b0, 32'h0,    1'b0, 32'h0,     32'h40,   1'b1, 32'h200);  // 18 collision write-first
    add_vec(1'b1, 32'h1040, 1'b1, 32'h400,   32'h40,   1'b1, 32'h200);  // 19 alias miss taken
    add_vec(1'b0, 32'h0,    1'b0, 32'h0,     32'h1040, 1'b1, 32'h400);  // 20 alias overwrote
    add_vec(1'b0, 32'h0,    1'b0, 32'h0,     32'h40,   1'b0, 32'h0);    // 21 old tag gone

    step();
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_pred_taken", 32'(pred_taken), 32'd0);
    chk("reset_pred_target", pred_target, 32'h0);
    rst = 1'b0;
    run_flush("flush0", 1000);

    foreach (vecs[i]) begin
      upd_en = vecs[i].ue; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
      upd_target = vecs[i].utgt; lookup_pc = vecs[i].lpc;
      step();
      chk($sformatf("row%0d_taken", i), 32'(pred_taken), 32'(vecs[i].etaken));
      chk($sformatf("row%0d_target", i), pred_target, vecs[i].etgt);
    end
    upd_en = 1'b0;

    // Reset mid-flush: lookup of a live entry must stay gated, then the flush restarts
    lookup_pc = 32'h1040;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      if (pred_taken !== 1'b0 || busy !== 1'b1) bad++;
      step();
    end
    chk("midflush_gated", 32'(bad), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_flush("flush1", -1);

    lookup_pc = 32'h1040;
    step();
    chk("post_flush_1040_taken", 32'(pred_taken), 32'd0);
    chk("post_flush_1040_target", pred_target, 32'h0);
    lookup_pc = 32'h80;
    step();
    chk("post_flush_80_taken", 32'(pred_taken), 32'd0);
    chk("post_flush_80_target", pred_target, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
